// File: rtl/adder_tree_sched.sv
// ============================================================================
// Module   : adder_tree_sched
// Brief    : Round-robin scheduler that feeds one shared 8-operand adder tree
//            and returns each sum tagged with its requester index.
//            Define ADDER_SCHED_PIPE_EN to register the level-2 sums
//            (latency 2 instead of 1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_tree_sched #(
    parameter int WIDTH = 7,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*8*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic                      rsp_valid,
    output logic [IDW-1:0]            rsp_id,
    output logic [WIDTH+2:0]          rsp_sum,
    output logic                      idle
);

    logic [IDW-1:0]   r_rr_ptr;
    logic [NREQ-1:0]  w_grant;
    logic [IDW-1:0]   w_gidx;
    logic             w_xfer;

    logic [WIDTH-1:0] r_op [8];
    logic [IDW-1:0]   r_s0_tag;
    logic             r_s0_vld;

    logic [WIDTH:0]   w_l3 [4];
    logic [WIDTH+1:0] w_l2 [2];
    logic [WIDTH+2:0] w_fin_sum;
    logic [IDW-1:0]   w_fin_tag;
    logic             w_fin_vld;
    logic             w_busy;

    // Grant the first valid requester at or after the pointer, wrapping.
    // rst_n gates the grant so req_ready stays low throughout reset.
    always_comb begin
        int  idx;
        logic found;
        w_grant = '0;
        w_gidx  = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(r_rr_ptr) + k) % NREQ;
            if (!found && en && rst_n && req_valid[idx]) begin
                found        = 1'b1;
                w_grant[idx] = 1'b1;
                w_gidx       = IDW'(idx);
            end
        end
    end

    assign req_ready = w_grant;
    assign w_xfer    = |(req_valid & w_grant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
            r_s0_vld <= 1'b0;
            r_s0_tag <= '0;
            for (int k = 0; k < 8; k++) r_op[k] <= '0;
        end else begin
            r_s0_vld <= w_xfer;
            if (w_xfer) begin
                r_rr_ptr <= (int'(w_gidx) == NREQ - 1) ? '0 : w_gidx + 1'b1;
                r_s0_tag <= w_gidx;
                for (int k = 0; k < 8; k++)
                    r_op[k] <= req_data[int'(w_gidx)*8*WIDTH + k*WIDTH +: WIDTH];
            end
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_l3
        assign w_l3[i] = {1'b0, r_op[2*i]} + {1'b0, r_op[2*i+1]};
    end

    for (genvar i = 0; i < 2; i++) begin : g_l2
        assign w_l2[i] = {1'b0, w_l3[2*i]} + {1'b0, w_l3[2*i+1]};
    end

`ifdef ADDER_SCHED_PIPE_EN
    logic [WIDTH+1:0] r_p_l2 [2];
    logic [IDW-1:0]   r_p_tag;
    logic             r_p_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_l2[0] <= '0;
            r_p_l2[1] <= '0;
            r_p_tag   <= '0;
            r_p_vld   <= 1'b0;
        end else begin
            r_p_l2[0] <= w_l2[0];
            r_p_l2[1] <= w_l2[1];
            r_p_tag   <= r_s0_tag;
            r_p_vld   <= r_s0_vld;
        end
    end

    assign w_fin_sum = {1'b0, r_p_l2[0]} + {1'b0, r_p_l2[1]};
    assign w_fin_tag = r_p_tag;
    assign w_fin_vld = r_p_vld;
    assign w_busy    = r_s0_vld | r_p_vld;
`else
    assign w_fin_sum = {1'b0, w_l2[0]} + {1'b0, w_l2[1]};
    assign w_fin_tag = r_s0_tag;
    assign w_fin_vld = r_s0_vld;
    assign w_busy    = r_s0_vld;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
        end else begin
            rsp_valid <= w_fin_vld;
            rsp_id    <= w_fin_tag;
            rsp_sum   <= w_fin_sum;
        end
    end

    assign idle = ~w_busy & ~w_xfer;

endmodule

`default_nettype wire

// File: tb/tb_adder_tree_sched.sv
// ============================================================================
// Module   : tb_adder_tree_sched
// Brief    : Directed + randomized bench for adder_tree_sched against a
//            queue-based reference model (honours ADDER_SCHED_PIPE_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_tree_sched;

    localparam int WIDTH = 7;
    localparam int NREQ  = 4;
    localparam int IDW   = $clog2(NREQ);
`ifdef ADDER_SCHED_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic                    clk;
    logic                    rst_n;
    logic                    en;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ*8*WIDTH-1:0] req_data;
    logic [NREQ-1:0]         req_ready;
    logic                    rsp_valid;
    logic [IDW-1:0]          rsp_id;
    logic [WIDTH+2:0]        rsp_sum;
    logic                    idle;

    adder_tree_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .idle      (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int due;
        int id;
        int sum;
    } rsp_t;

    rsp_t q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   cyc        = 0;
    int   ptr        = 0;
    int   granted    = -1;
    int   pulses     = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_sum(input int g);
        int s = 0;
        for (int k = 0; k < 8; k++)
            s += int'(req_data[g*8*WIDTH + k*WIDTH +: WIDTH]);
        return s;
    endfunction

    // Winner = valid requester with the smallest wrapped distance from ptr.
    function automatic int ref_grant();
        int best  = -1;
        int bestd = NREQ;
        if (!en) return -1;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && ((i - ptr + NREQ) % NREQ) < bestd) begin
                bestd = (i - ptr + NREQ) % NREQ;
                best  = i;
            end
        end
        return best;
    endfunction

    task automatic set_ops(input int g);
        for (int k = 0; k < 8; k++)
            req_data[g*8*WIDTH + k*WIDTH +: WIDTH] = WIDTH'($urandom);
    endtask

    task automatic cycle();
        rsp_t        e;
        logic        exp_v;
        logic [31:0] exp_ready;
        int          g;
        @(negedge clk);
        exp_v = 1'b0;
        e     = '{0, 0, 0};
        if (q.size() > 0 && q[0].due == cyc) begin
            e     = q.pop_front();
            exp_v = 1'b1;
        end
        check("rsp_valid", 32'(rsp_valid), 32'(exp_v));
        if (exp_v) begin
            check("rsp_id", 32'(rsp_id), e.id);
            check("rsp_sum", 32'(rsp_sum), e.sum);
        end
        if (rsp_valid === 1'b1) pulses++;
        g         = ref_grant();
        exp_ready = (g >= 0) ? (32'd1 << g) : 32'd0;
        check("req_ready", 32'(req_ready), exp_ready);
        check("idle", 32'(idle), 32'((q.size() == 0) && (g < 0)));
        granted = g;
        if (g >= 0) begin
            q.push_back('{cyc + 1 + LAT, g, ref_sum(g)});
            ptr = (g + 1) % NREQ;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    int grants3;

    initial begin
        rst_n     = 1'b0;
        en        = 1'b0;
        req_valid = '0;
        req_data  = '0;
        #1;
        check("reset_rsp_valid", 32'(rsp_valid), 0);
        check("reset_rsp_sum", 32'(rsp_sum), 0);
        check("reset_rsp_id", 32'(rsp_id), 0);
        check("reset_req_ready", 32'(req_ready), 0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Requester 2 alone, operands 1..8 (sum 36)
        en = 1'b1;
        for (int k = 0; k < 8; k++)
            req_data[2*8*WIDTH + k*WIDTH +: WIDTH] = WIDTH'(k + 1);
        req_valid = 4'b0100;
        #1 check("single_ready", 32'(req_ready), 32'h4);
        cycle();
        req_valid = '0;
        repeat (LAT + 1) cycle();

        // All four requesting: pointer is now 3
        req_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) set_ops(i);
        #1 check("ptr_after_single", 32'(req_ready), 32'h8);
        repeat (8) begin
            cycle();
            if (granted >= 0) set_ops(granted);
        end
        req_valid = '0;
        repeat (LAT + 1) cycle();

        // Maximum operands from requester 1
        for (int k = 0; k < 8; k++)
            req_data[1*8*WIDTH + k*WIDTH +: WIDTH] = 7'h7F;
        req_valid = 4'b0010;
        cycle();
        req_valid = '0;
        repeat (LAT) cycle();
        check("max_sum", 32'(rsp_sum), 32'd1016);
        cycle();

        // Three transfers then en low with requests still pending
        pulses    = 0;
        req_valid = 4'b1111;
        repeat (3) begin
            cycle();
            if (granted >= 0) set_ops(granted);
        end
        en = 1'b0;
        repeat (LAT + 3) cycle();
        check("en_off_pulses", pulses, 3);
        check("en_off_idle", 32'(idle), 1);
        check("en_off_ready", 32'(req_ready), 0);

        // Reset one cycle after a transfer discards the in-flight sum
        en        = 1'b1;
        req_valid = 4'b0100;
        set_ops(2);
        cycle();
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", 32'(rsp_valid), 0);
        check("midrst_rsp_sum", 32'(rsp_sum), 0);
        check("midrst_req_ready", 32'(req_ready), 0);
        q.delete();
        ptr       = 0;
        req_valid = '0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (LAT + 2) cycle();
        req_valid = 4'b1111;
        #1 check("ptr_after_reset", 32'(req_ready), 32'h1);
        cycle();
        req_valid = '0;
        repeat (LAT + 1) cycle();

        // Requester 3 holds while requester 0 keeps re-requesting
        grants3   = 0;
        req_valid = 4'b1001;
        set_ops(0);
        set_ops(3);
        for (int c = 0; c < 6; c++) begin
            cycle();
            if (granted == 3 && c < 4) grants3++;
            if (granted >= 0) set_ops(granted);
        end
        check("fair_r3_within4", 32'(grants3 > 0), 1);
        req_valid = '0;
        repeat (LAT + 1) cycle();

        // Randomized traffic with hold-until-granted requesters
        for (int c = 0; c < 400; c++) begin
            en = ($urandom % 8) != 0;
            cycle();
            if (granted >= 0) begin
                req_valid[granted] = 1'($urandom % 2);
                set_ops(granted);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && (i != granted) && ($urandom % 3 == 0)) begin
                    req_valid[i] = 1'b1;
                    set_ops(i);
                end
            end
        end
        req_valid = '0;
        repeat (LAT + 2) cycle();
        check("final_idle", 32'(idle), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
